// File: rtl/gth_link_pkg.sv
// gth_link_pkg
// Shared types and constants for the GTH TMDS link sequencer.
//   link_state_t  : sequencer states, WAIT through FAILED
//   TMDS_CTRL_xx  : the four TMDS control tokens, suffix is C1C0
//   CNT_W         : width of the shared settle/preamble/recover counter
package gth_link_pkg;

  typedef enum logic [2:0] {
    WAIT,
    SETTLE,
    PREAMBLE,
    STREAM,
    RECOVER,
    FAILED
  } link_state_t;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  localparam int CNT_W = 16;

endpackage

// File: rtl/gth_sync2.sv
// gth_sync2
// Two-flop synchroniser for quasi-static status levels crossing into the
// serializer write clock domain. Each bit is synchronised independently.
//   txoutclk_internal : destination clock
//   reset             : synchronous active-high reset, clears both stages
//   d                 : asynchronous input vector
//   q                 : synchronised output vector
module gth_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             txoutclk_internal,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge txoutclk_internal) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gth_link_sequencer.sv
// gth_link_sequencer
// Bring-up and run-time controller for the 3-lane GTH TMDS serializer.
// Waits for transceiver/clock/power status, holds a settle interval, sends
// a control-token preamble, then streams pixel symbols. Loss of readiness
// or FIFO underflow forces a recovery (tokens + datapath reset pulse);
// after MAX_RETRIES recoveries the block latches a fault until reset.
//   txoutclk_internal : 148.5 MHz serializer write clock
//   reset             : synchronous active-high reset
//   tx_done, locked, gtpowergood[2:0], txpmaresetdone[2:0] : async status
//   underflow         : FIFO underflow level from the pixel clock domain
//   pix_r/g/b, pix_valid, pix_ready : pixel symbol handshake
//   r, g, b           : registered symbols to the serializer lanes
//   dp_reset_req      : datapath reset request, high during recovery
//   link_up, fault    : high in STREAM / FAILED respectively
//   retry_count       : recoveries since reset, saturating at 15
module gth_link_sequencer
  import gth_link_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES      = 1024,
  parameter int unsigned PREAMBLE_CYCLES    = 64,
  parameter int unsigned RESET_PULSE_CYCLES = 16,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       txoutclk_internal,
  input  logic       reset,
  input  logic       tx_done,
  input  logic       locked,
  input  logic [2:0] gtpowergood,
  input  logic [2:0] txpmaresetdone,
  input  logic       underflow,
  input  logic [9:0] pix_r,
  input  logic [9:0] pix_g,
  input  logic [9:0] pix_b,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [9:0] r,
  output logic [9:0] g,
  output logic [9:0] b,
  output logic       dp_reset_req,
  output logic       link_up,
  output logic       fault,
  output logic [3:0] retry_count
);

  // Counter reloads are PARAM-1 so each timed state lasts exactly PARAM cycles.
  localparam logic [CNT_W-1:0] SETTLE_LOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PREAMBLE_LOAD = CNT_W'(PREAMBLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD  = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT   = 4'(MAX_RETRIES);

  logic [7:0]       status_sync;
  logic             underflow_sync;
  logic             all_ready;
  logic             go_recover;
  link_state_t      state;
  logic [CNT_W-1:0] count;

  gth_sync2 #(.WIDTH(8)) u_status_sync (
    .txoutclk_internal (txoutclk_internal),
    .reset             (reset),
    .d                 ({tx_done, locked, gtpowergood, txpmaresetdone}),
    .q                 (status_sync)
  );

  gth_sync2 #(.WIDTH(1)) u_underflow_sync (
    .txoutclk_internal (txoutclk_internal),
    .reset             (reset),
    .d                 (underflow),
    .q                 (underflow_sync)
  );

  assign all_ready = &status_sync;

  // Both recovery causes share one entry so a simultaneous underflow and
  // loss of readiness counts as a single retry.
  always_comb begin
    go_recover = 1'b0;
    if (state == PREAMBLE && !all_ready) begin
      go_recover = 1'b1;
    end
    if (state == STREAM && (!all_ready || underflow_sync)) begin
      go_recover = 1'b1;
    end
  end

  always_ff @(posedge txoutclk_internal) begin
    if (reset) begin
      state        <= WAIT;
      count        <= '0;
      r            <= TMDS_CTRL_00;
      g            <= TMDS_CTRL_00;
      b            <= TMDS_CTRL_00;
      pix_ready    <= 1'b0;
      dp_reset_req <= 1'b0;
      link_up      <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= '0;
    end else begin
      // pix_ready is high exactly while in STREAM, so the pixel accepted in
      // the last STREAM cycle still reaches the lanes on the leaving edge.
      if (pix_ready && pix_valid) begin
        r <= pix_r;
        g <= pix_g;
        b <= pix_b;
      end else begin
        r <= TMDS_CTRL_00;
        g <= TMDS_CTRL_00;
        b <= TMDS_CTRL_00;
      end

      if (go_recover) begin
        state        <= RECOVER;
        count        <= RECOVER_LOAD;
        dp_reset_req <= 1'b1;
        pix_ready    <= 1'b0;
        link_up      <= 1'b0;
        if (retry_count != 4'hF) begin
          retry_count <= retry_count + 4'd1;
        end
      end else begin
        case (state)
          WAIT: begin
            if (all_ready) begin
              state <= SETTLE;
              count <= SETTLE_LOAD;
            end
          end
          SETTLE: begin
            if (!all_ready) begin
              state <= WAIT;
            end else if (count == '0) begin
              state <= PREAMBLE;
              count <= PREAMBLE_LOAD;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
          PREAMBLE: begin
            if (count == '0) begin
              state     <= STREAM;
              pix_ready <= 1'b1;
              link_up   <= 1'b1;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
          STREAM: begin
          end
          RECOVER: begin
            if (count == '0) begin
              dp_reset_req <= 1'b0;
              if (retry_count >= RETRY_LIMIT) begin
                state <= FAILED;
                fault <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else begin
              count <= count - CNT_W'(1);
            end
          end
          FAILED: begin
          end
          default: begin
            state <= WAIT;
          end
        endcase
      end
    end
  end

endmodule
